// File: rtl/counter_sequencer.sv
// Prescaled up/down counter with run/pause/done sequencing for the LED counter display.
// A programmable prescaler produces the count tick; commands start, stop, clear and load the counter.
module counter_sequencer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic             iCLK_50,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iSTOP,
    input  logic             iCLEAR,
    input  logic             iLOAD,
    input  logic [CNT_W-1:0] iLOAD_VAL,
    input  logic             iUP,
    input  logic [CNT_W-1:0] iLIMIT,
    input  logic             iAUTO_RELOAD,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oTICK,
    output logic             oDONE,
    output logic             oRUNNING,
    output logic [1:0]       oSTATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               reload_q, reload_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               running_q, running_d;

    logic               run_en_c;
    logic [CNT_W-1:0]   step_val_c;
    logic [CNT_W-1:0]   start_val_c;
    logic [CNT_W-1:0]   term_val_c;

    // Direction-dependent next value, restart value and terminal value.
    always_comb begin
        step_val_c  = iUP ? (count_q + CNT_W'(1)) : (count_q - CNT_W'(1));
        start_val_c = iUP ? '0 : iLIMIT;
        term_val_c  = iUP ? iLIMIT : '0;
    end

    // Command decode (clear > load > stop > start), then prescaler and count advance in RUN.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        reload_d  = reload_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        run_en_c  = 1'b0;

        if (iCLEAR) begin
            count_d  = '0;
            presc_d  = '0;
            reload_d = 1'b0;
            state_d  = ST_IDLE;
        end else if (iLOAD) begin
            count_d  = iLOAD_VAL;
            presc_d  = '0;
            reload_d = 1'b0;
            state_d  = ST_IDLE;
        end else if (iSTOP) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (iSTART) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_DONE: begin
                    state_d  = ST_RUN;
                    count_d  = start_val_c;
                    presc_d  = '0;
                    reload_d = 1'b0;
                end
                default: run_en_c = (state_q == ST_RUN);
            endcase
        end else begin
            run_en_c = (state_q == ST_RUN);
        end

        if (run_en_c) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (reload_q) begin
                    count_d  = start_val_c;
                    reload_d = 1'b0;
                end else begin
                    count_d = step_val_c;
                    if (step_val_c == term_val_c) begin
                        done_d = 1'b1;
                        if (iAUTO_RELOAD) begin
                            reload_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            reload_q  <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign oCOUNT   = count_q;
    assign oTICK    = tick_q;
    assign oDONE    = done_q;
    assign oRUNNING = running_q;
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed scenarios followed by random commands,
// with expected outputs queued from a cycle-level reference model.
module tb_counter_sequencer;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DIV_W    = 3;

    logic             clk;
    logic             iRST, iSTART, iSTOP, iCLEAR, iLOAD, iUP, iAUTO_RELOAD;
    logic [CNT_W-1:0] iLOAD_VAL, iLIMIT;
    logic [CNT_W-1:0] oCOUNT;
    logic             oTICK, oDONE, oRUNNING;
    logic [1:0]       oSTATE;

    counter_sequencer #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
        .iCLK_50      (clk),
        .iRST         (iRST),
        .iSTART       (iSTART),
        .iSTOP        (iSTOP),
        .iCLEAR       (iCLEAR),
        .iLOAD        (iLOAD),
        .iLOAD_VAL    (iLOAD_VAL),
        .iUP          (iUP),
        .iLIMIT       (iLIMIT),
        .iAUTO_RELOAD (iAUTO_RELOAD),
        .oCOUNT       (oCOUNT),
        .oTICK        (oTICK),
        .oDONE        (oDONE),
        .oRUNNING     (oRUNNING),
        .oSTATE       (oSTATE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] count;
        logic       tick;
        logic       done;
        logic       running;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: 0 idle, 1 run, 2 done; plain integer arithmetic modulo 256.
    int m_state = 0;
    int m_presc = 0;
    int m_count = 0;
    bit m_reload = 0;
    bit m_tick = 0;
    bit m_done = 0;

    bit   g_up = 1'b1;
    bit   g_auto = 1'b0;
    int   g_limit = 3;

    function automatic void model_tick_cycle();
        if (m_presc < int'(TICK_DIV) - 1) begin
            m_presc++;
            return;
        end
        m_presc = 0;
        m_tick  = 1;
        if (m_reload) begin
            m_count  = iUP ? 0 : int'(iLIMIT);
            m_reload = 0;
            return;
        end
        m_count = iUP ? (m_count + 1) % 256 : (m_count + 255) % 256;
        if (m_count == (iUP ? int'(iLIMIT) : 0)) begin
            m_done = 1;
            if (iAUTO_RELOAD) m_reload = 1;
            else m_state = 2;
        end
    endfunction

    function automatic void model_step();
        m_tick = 0;
        m_done = 0;
        if (iRST) begin
            m_state = 0; m_presc = 0; m_count = 0; m_reload = 0;
        end else if (iCLEAR) begin
            m_state = 0; m_presc = 0; m_count = 0; m_reload = 0;
        end else if (iLOAD) begin
            m_state = 0; m_presc = 0; m_count = int'(iLOAD_VAL); m_reload = 0;
        end else if (iSTOP) begin
            if (m_state == 1) m_state = 0;
        end else if (iSTART) begin
            if (m_state == 0) m_state = 1;
            else if (m_state == 2) begin
                m_state = 1; m_presc = 0; m_reload = 0;
                m_count = iUP ? 0 : int'(iLIMIT);
            end else model_tick_cycle();
        end else if (m_state == 1) begin
            model_tick_cycle();
        end
    endfunction

    task automatic drive(input bit rst, input bit st, input bit sp, input bit cl,
                         input bit ld, input logic [7:0] lv);
        exp_t e;
        @(negedge clk);
        iRST = rst; iSTART = st; iSTOP = sp; iCLEAR = cl; iLOAD = ld; iLOAD_VAL = lv;
        iUP = g_up; iAUTO_RELOAD = g_auto; iLIMIT = 8'(g_limit);
        model_step();
        e.count   = 8'(m_count);
        e.tick    = m_tick;
        e.done    = m_done;
        e.running = (m_state == 1);
        e.state   = 2'(m_state);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: compares every registered output cycle against the queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {oCOUNT, oTICK, oDONE, oRUNNING, oSTATE};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t act cnt=%02h tick=%0b done=%0b run=%0b st=%0d req cnt=%02h tick=%0b done=%0b run=%0b st=%0d",
                             $time, a.count, a.tick, a.done, a.running, a.state,
                             e.count, e.tick, e.done, e.running, e.state);
                end
            end
        end
    end

    initial begin
        iRST = 1; iSTART = 0; iSTOP = 0; iCLEAR = 0; iLOAD = 0; iLOAD_VAL = '0;
        iUP = 1; iLIMIT = 8'd3; iAUTO_RELOAD = 0;

        // Reset, then up-count to 3 and stop in DONE.
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(40);

        // Auto-reload up mode.
        g_auto = 1;
        drive(0, 0, 0, 1, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(40);

        // Down mode with reload to limit.
        g_up = 0; g_limit = 5;
        drive(0, 0, 0, 0, 1, 8'h02);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(40);

        // Pause two cycles after a tick, resume later.
        g_up = 1; g_limit = 200; g_auto = 0;
        drive(0, 0, 0, 1, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(6);
        drive(0, 0, 1, 0, 0, 8'h00);
        idle(10);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(10);

        // Clear exactly on the tick cycle, then load colliding with start.
        drive(0, 0, 0, 1, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(3);
        drive(0, 0, 0, 1, 0, 8'h00);
        idle(3);
        drive(0, 1, 0, 0, 1, 8'h80);
        idle(3);

        // Wrap up from 0xFF and down from 0x00.
        g_limit = 8'h10;
        drive(0, 0, 0, 0, 1, 8'hFF);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(6);
        g_up = 0;
        drive(0, 0, 0, 0, 1, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        idle(6);

        // Reset in the middle of a run.
        drive(1, 0, 0, 0, 0, 8'h00);
        idle(3);

        // Random commands with occasional configuration changes.
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) begin
                g_up    = $urandom_range(0, 1) == 1;
                g_auto  = $urandom_range(0, 1) == 1;
                g_limit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                      : int'($urandom_range(0, 7));
            end
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 59) == 0,
                  8'($urandom_range(0, 255)));
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d pending, req=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
